fetch_pc_unit: RTL and testbench

PC register and instruction-fetch stage feeding the IF/ID pipeline register.
- Consumes the branch unit's redirect outputs (PcSel, BrPC) and drives its Cur_PC input.
- Issues single-outstanding requests to a variable-latency instruction memory.
- Buffers one returned instruction across decode stalls.
- Handles flush on redirect and a terminal halt state.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_skid_buffer.sv | 48 ++++
 rtl/fetch_pc_unit.sv | 164 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states,
// the IF/ID register layout and the PC alignment helper.
package fetch_pkg;

  localparam int          PC_W      = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_FLUSH = '{pc: {PC_W{1'b0}}, instr: NOP_INSTR, valid: 1'b0};

  // Redirect targets are truncated to the PC width and forced word aligned.
  function automatic logic [PC_W-1:0] pc_align(input logic [31:0] target);
    return {target[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register that parks a fetched instruction while decode
// is stalled. clear has priority over load, load over drain.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [PC_W-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_valid
);

  if_id_t entry_d;
  if_id_t entry_q;

  // Next-entry selection.
  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d = IF_ID_FLUSH;
    end else if (load) begin
      entry_d = '{pc: load_pc, instr: load_instr, valid: 1'b1};
    end else if (drain) begin
      entry_d.valid = 1'b0;
    end else begin
      entry_d = entry_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q <= IF_ID_FLUSH;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign out_pc    = entry_q.pc;
  assign out_instr = entry_q.instr;
  assign out_valid = entry_q.valid;

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch stage: single-outstanding requests to a
// variable-latency instruction memory, decode-stall skid, redirect kill, halt.
module fetch_pc_unit
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic            Halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] Cur_PC,
  output logic [PC_W-1:0] IfId_Pc,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Halted
);

  fetch_state_e    state_d, state_q;
  logic [PC_W-1:0] cur_pc_d, cur_pc_q;
  logic [PC_W-1:0] addr_d, addr_q;
  logic            req_d, req_q;
  logic            kill_d, kill_q;
  if_id_t          ifid_d, ifid_q;

  logic            rsp_s;
  logic            skid_load_s, skid_drain_s, skid_clear_s;
  logic [PC_W-1:0] skid_pc_s;
  logic [31:0]     skid_instr_s;
  logic            skid_valid_s;
  logic [PC_W-1:0] br_target_s;
  logic            unused_br_s;

  assign rsp_s       = req_q & imem_ready;
  assign br_target_s = pc_align(BrPC);
  assign unused_br_s = ^{BrPC[31:PC_W], BrPC[1:0]};

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (skid_load_s),
    .drain      (skid_drain_s),
    .clear      (skid_clear_s),
    .load_pc    (addr_q),
    .load_instr (imem_rdata),
    .out_pc     (skid_pc_s),
    .out_instr  (skid_instr_s),
    .out_valid  (skid_valid_s)
  );

  // Next-state, PC and IF/ID update; priority halt > redirect > stall > normal.
  always_comb begin
    state_d      = state_q;
    cur_pc_d     = cur_pc_q;
    addr_d       = addr_q;
    req_d        = req_q;
    kill_d       = kill_q;
    ifid_d       = ifid_q;
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_clear_s = 1'b0;
    case (state_q)
      ST_REQ, ST_HOLD: begin
        if (Halt_req) begin
          state_d      = ST_HALTED;
          req_d        = 1'b0;
          kill_d       = 1'b0;
          ifid_d       = IF_ID_FLUSH;
          skid_clear_s = 1'b1;
        end else if (PcSel) begin
          state_d      = ST_REQ;
          cur_pc_d     = br_target_s;
          req_d        = 1'b1;
          ifid_d       = IF_ID_FLUSH;
          skid_clear_s = 1'b1;
          // An unanswered request must complete at its old address before refetch.
          if (req_q && !imem_ready) begin
            kill_d = 1'b1;
          end else begin
            kill_d = 1'b0;
            addr_d = br_target_s;
          end
        end else if (state_q == ST_HOLD) begin
          if (!Stall) begin
            ifid_d       = '{pc: skid_pc_s, instr: skid_instr_s, valid: skid_valid_s};
            skid_drain_s = 1'b1;
            cur_pc_d     = cur_pc_q + PC_W'(4);
            addr_d       = cur_pc_q + PC_W'(4);
            req_d        = 1'b1;
            state_d      = ST_REQ;
          end else begin
            ifid_d = ifid_q;
          end
        end else if (rsp_s && !kill_q && !Stall) begin
          ifid_d   = '{pc: addr_q, instr: imem_rdata, valid: 1'b1};
          cur_pc_d = addr_q + PC_W'(4);
          addr_d   = addr_q + PC_W'(4);
        end else if (rsp_s && !kill_q) begin
          skid_load_s = 1'b1;
          state_d     = ST_HOLD;
          req_d       = 1'b0;
        end else begin
          req_d = 1'b1;
          if (rsp_s) begin
            kill_d = 1'b0;
            addr_d = cur_pc_q;
          end else begin
            kill_d = kill_q;
          end
          if (!Stall) begin
            ifid_d.valid = 1'b0;
          end else begin
            ifid_d = ifid_q;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
        req_d   = 1'b0;
        kill_d  = 1'b0;
        ifid_d  = IF_ID_FLUSH;
      end
      default: begin
        state_d      = ST_HALTED;
        req_d        = 1'b0;
        kill_d       = 1'b0;
        ifid_d       = IF_ID_FLUSH;
        skid_clear_s = 1'b1;
      end
    endcase
  end

  // Fetch-stage state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_REQ;
      cur_pc_q <= {PC_W{1'b0}};
      addr_q   <= {PC_W{1'b0}};
      req_q    <= 1'b0;
      kill_q   <= 1'b0;
      ifid_q   <= IF_ID_FLUSH;
    end else begin
      state_q  <= state_d;
      cur_pc_q <= cur_pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      kill_q   <= kill_d;
      ifid_q   <= ifid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign Cur_PC     = cur_pc_q;
  assign IfId_Pc    = ifid_q.pc;
  assign IfId_Instr = ifid_q.instr;
  assign IfId_Valid = ifid_q.valid;
  assign Halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: memory returns address-tagged words,
// ready is driven per cycle, expectations are hand-computed.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hA500_0000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       PcSel;
  logic [31:0] BrPC;
  logic       Stall;
  logic       Halt_req;
  logic       imem_req;
  logic [8:0] imem_addr;
  logic       imem_ready;
  logic [31:0] imem_rdata;
  logic [8:0] Cur_PC;
  logic [8:0] IfId_Pc;
  logic [31:0] IfId_Instr;
  logic       IfId_Valid;
  logic       Halted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = TAG | {23'd0, imem_addr};

  fetch_pc_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Stall      (Stall),
    .Halt_req   (Halt_req),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .Cur_PC     (Cur_PC),
    .IfId_Pc    (IfId_Pc),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid),
    .Halted     (Halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, " Cur_PC"},     32'(Cur_PC),     32'h0);
    check_val({tag, " imem_addr"},  32'(imem_addr),  32'h0);
    check_val({tag, " imem_req"},   32'(imem_req),   32'h0);
    check_val({tag, " IfId_Pc"},    32'(IfId_Pc),    32'h0);
    check_val({tag, " IfId_Instr"}, IfId_Instr,      NOP);
    check_val({tag, " IfId_Valid"}, 32'(IfId_Valid), 32'h0);
    check_val({tag, " Halted"},     32'(Halted),     32'h0);
  endtask

  initial begin
    reset_n = 1'b0; PcSel = 1'b0; BrPC = 32'h0; Stall = 1'b0;
    Halt_req = 1'b0; imem_ready = 1'b1;
    tick;
    check_reset_vals("reset");
    reset_n = 1'b1;
    check_val("post-reset req low", 32'(imem_req), 32'h0);

    // Zero-bubble stream with single-cycle memory.
    tick;
    check_val("first req", 32'(imem_req), 32'h1);
    check_val("first addr", 32'(imem_addr), 32'h0);
    check_val("first valid", 32'(IfId_Valid), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick;
      check_val("stream pc", 32'(IfId_Pc), 32'(i * 4));
      check_val("stream instr", IfId_Instr, TAG | 32'(i * 4));
      check_val("stream valid", 32'(IfId_Valid), 32'h1);
      check_val("stream Cur_PC", 32'(Cur_PC), 32'(i * 4 + 4));
    end

    // Stall while word 0x08 returns: parked in skid for three cycles.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_val("stall hold pc", 32'(IfId_Pc), 32'h4);
      check_val("stall req low", 32'(imem_req), 32'h0);
      check_val("stall Cur_PC", 32'(Cur_PC), 32'h8);
    end
    Stall = 1'b0;
    tick;
    check_val("drain pc", 32'(IfId_Pc), 32'h8);
    check_val("drain instr", IfId_Instr, TAG | 32'h8);
    check_val("drain valid", 32'(IfId_Valid), 32'h1);
    check_val("drain Cur_PC", 32'(Cur_PC), 32'hC);
    check_val("drain addr", 32'(imem_addr), 32'hC);
    check_val("drain req", 32'(imem_req), 32'h1);
    tick;
    check_val("after drain pc", 32'(IfId_Pc), 32'hC);

    // Redirect while fetch of 0x10 is pending; a second redirect overrides.
    imem_ready = 1'b0; PcSel = 1'b1; BrPC = 32'h40;
    tick;
    check_val("kill Cur_PC", 32'(Cur_PC), 32'h40);
    check_val("kill addr stable", 32'(imem_addr), 32'h10);
    check_val("kill req", 32'(imem_req), 32'h1);
    check_val("kill flush valid", 32'(IfId_Valid), 32'h0);
    check_val("kill flush instr", IfId_Instr, NOP);
    PcSel = 1'b0;
    tick;
    check_val("kill wait valid", 32'(IfId_Valid), 32'h0);
    PcSel = 1'b1; BrPC = 32'h80;
    tick;
    check_val("rekill Cur_PC", 32'(Cur_PC), 32'h80);
    check_val("rekill addr", 32'(imem_addr), 32'h10);
    PcSel = 1'b0; imem_ready = 1'b1;
    tick;
    check_val("discard valid", 32'(IfId_Valid), 32'h0);
    check_val("refetch addr", 32'(imem_addr), 32'h80);
    check_val("refetch req", 32'(imem_req), 32'h1);
    tick;
    check_val("target pc", 32'(IfId_Pc), 32'h80);
    check_val("target instr", IfId_Instr, TAG | 32'h80);
    check_val("target valid", 32'(IfId_Valid), 32'h1);
    check_val("target Cur_PC", 32'(Cur_PC), 32'h84);

    // Redirect coinciding with ready, unaligned target near the top, then wrap.
    PcSel = 1'b1; BrPC = 32'h1FF;
    tick;
    check_val("wrap Cur_PC", 32'(Cur_PC), 32'h1FC);
    check_val("wrap addr", 32'(imem_addr), 32'h1FC);
    check_val("wrap flush valid", 32'(IfId_Valid), 32'h0);
    PcSel = 1'b0;
    tick;
    check_val("wrap top pc", 32'(IfId_Pc), 32'h1FC);
    check_val("wrap Cur_PC zero", 32'(Cur_PC), 32'h0);
    tick;
    check_val("wrap next pc", 32'(IfId_Pc), 32'h0);
    check_val("wrap next Cur_PC", 32'(Cur_PC), 32'h4);

    // Halt beats a simultaneous redirect and stall, then sticks.
    Halt_req = 1'b1; PcSel = 1'b1; BrPC = 32'h100; Stall = 1'b1;
    tick;
    check_val("halt Halted", 32'(Halted), 32'h1);
    check_val("halt req", 32'(imem_req), 32'h0);
    check_val("halt valid", 32'(IfId_Valid), 32'h0);
    check_val("halt Cur_PC", 32'(Cur_PC), 32'h4);
    Halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Stall = i[0];
      tick;
      check_val("halted sticky", 32'(Halted), 32'h1);
      check_val("halted req", 32'(imem_req), 32'h0);
      check_val("halted valid", 32'(IfId_Valid), 32'h0);
      check_val("halted Cur_PC", 32'(Cur_PC), 32'h4);
    end
    PcSel = 1'b0; Stall = 1'b0;

    // Async reset pulse between edges in the middle of a stream.
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    repeat (3) tick;
    check_val("restream pc", 32'(IfId_Pc), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async reset");
    #1;
    reset_n = 1'b1;
    tick;
    check_val("restart req", 32'(imem_req), 32'h1);
    check_val("restart addr", 32'(imem_addr), 32'h0);
    tick;
    check_val("restart pc", 32'(IfId_Pc), 32'h0);
    check_val("restart valid", 32'(IfId_Valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
